// File: rtl/ddr3_rw_sched.sv
// ddr3_rw_sched: burst scheduler between camera write FIFO and LCD read FIFO with ping-pong frame banks.
// Define DDR_SCHED_WR_PRIORITY_EN to let writes win every tie instead of round-robin.
module ddr3_rw_sched #(
    parameter int ADDR_W    = 28,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 11,
    parameter int BANK_BIT  = 25,
    parameter int RD_THRESH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ddr3_init_done,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              pingpang_en,
    input  logic [CNT_W-1:0]  wfifo_rcount,
    input  logic [CNT_W-1:0]  rfifo_wcount,
    input  logic [ADDR_W-1:0] addr_wd_min,
    input  logic [ADDR_W-1:0] addr_wd_max,
    input  logic [ADDR_W-1:0] addr_rd_min,
    input  logic [ADDR_W-1:0] addr_rd_max,
    input  logic [LEN_W-1:0]  wd_burst_len,
    input  logic [LEN_W-1:0]  rd_burst_len,
    output logic              cmd_wr_req,
    output logic              cmd_rd_req,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ack,
    input  logic              burst_done,
    output logic              wfifo_flush,
    output logic              rfifo_flush,
    output logic              wr_bank,
    output logic              rd_bank
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
`ifdef DDR_SCHED_WR_PRIORITY_EN
    localparam logic WR_PRIO = 1'b1;
`else
    localparam logic WR_PRIO = 1'b0;
`endif
    state_t            state_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, cmd_addr_q, wr_ptr_d, rd_ptr_d, wr_addr, rd_addr;
    logic [LEN_W-1:0]  cmd_len_q;
    logic [ADDR_W:0]   step, wr_sum, rd_sum;
    logic cmd_wr_req_q, cmd_rd_req_q, wfifo_flush_q, rfifo_flush_q, wr_bank_q, rd_bank_q;
    logic wr_bank_d, rd_bank_d, last_wr_q, wl_q1, wl_q2, rl_q1, rl_q2, wr_pend_q, rd_pend_q;
    logic wr_need, rd_need, pick_wr, pick_rd, wr_done, rd_done, wr_apply, rd_apply;
    logic wr_busy, rd_busy, wr_wrap, rd_wrap;
    assign wr_need  = (wfifo_rcount >= CNT_W'(wd_burst_len)) && (wd_burst_len != '0);
    assign rd_need  = (rfifo_wcount < CNT_W'(RD_THRESH)) && (rd_burst_len != '0);
    assign pick_wr  = wr_need && (!rd_need || WR_PRIO || !last_wr_q);
    assign pick_rd  = rd_need && !pick_wr;
    assign wr_busy  = state_q inside {WR_REQ, WR_WAIT};
    assign rd_busy  = state_q inside {RD_REQ, RD_WAIT};
    assign wr_done  = state_q == WR_WAIT && burst_done && ddr3_init_done;
    assign rd_done  = state_q == RD_WAIT && burst_done && ddr3_init_done;
    // A load seen while its path is busy waits for that burst to finish, then overrides its advance.
    assign wr_apply = ((wl_q1 && !wl_q2) || wr_pend_q) && (!wr_busy || wr_done);
    assign rd_apply = ((rl_q1 && !rl_q2) || rd_pend_q) && (!rd_busy || rd_done);
    assign step     = {{(ADDR_W+1-LEN_W){1'b0}}, cmd_len_q} << 3;
    assign wr_sum   = {1'b0, wr_ptr_q} + step;
    assign rd_sum   = {1'b0, rd_ptr_q} + step;
    assign wr_wrap  = wr_sum >= {1'b0, addr_wd_max};
    assign rd_wrap  = rd_sum >= {1'b0, addr_rd_max};
    assign wr_ptr_d = wr_apply ? addr_wd_min : !wr_done ? wr_ptr_q : wr_wrap ? addr_wd_min : wr_sum[ADDR_W-1:0];
    assign rd_ptr_d = rd_apply ? addr_rd_min : !rd_done ? rd_ptr_q : rd_wrap ? addr_rd_min : rd_sum[ADDR_W-1:0];
    assign wr_bank_d = pingpang_en && (wr_bank_q ^ (wr_done && !wr_apply && wr_wrap));
    assign rd_bank_d = pingpang_en && (rd_apply ? !wr_bank_q : rd_bank_q);
    always_comb begin
        wr_addr = wr_ptr_d;
        wr_addr[BANK_BIT] = wr_bank_d;
        rd_addr = rd_ptr_d;
        rd_addr[BANK_BIT] = rd_bank_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            {wr_ptr_q, rd_ptr_q, cmd_addr_q, cmd_len_q} <= '0;
            {cmd_wr_req_q, cmd_rd_req_q, wfifo_flush_q, rfifo_flush_q} <= '0;
            {wr_bank_q, rd_bank_q, wl_q1, wl_q2, rl_q1, rl_q2, wr_pend_q, rd_pend_q} <= '0;
            last_wr_q     <= 1'b1;
        end else begin
            {wl_q1, wl_q2, rl_q1, rl_q2} <= {wr_load, wl_q1, rd_load, rl_q1};
            wr_pend_q     <= ((wl_q1 && !wl_q2) || wr_pend_q) && !wr_apply;
            rd_pend_q     <= ((rl_q1 && !rl_q2) || rd_pend_q) && !rd_apply;
            wfifo_flush_q <= wr_apply;
            rfifo_flush_q <= rd_apply;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            if (!ddr3_init_done) begin
                state_q      <= IDLE;
                cmd_wr_req_q <= 1'b0;
                cmd_rd_req_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (pick_wr) begin
                        state_q      <= WR_REQ;
                        cmd_wr_req_q <= 1'b1;
                        cmd_addr_q   <= wr_addr;
                        cmd_len_q    <= wd_burst_len;
                        last_wr_q    <= 1'b1;
                    end else if (pick_rd) begin
                        state_q      <= RD_REQ;
                        cmd_rd_req_q <= 1'b1;
                        cmd_addr_q   <= rd_addr;
                        cmd_len_q    <= rd_burst_len;
                        last_wr_q    <= 1'b0;
                    end
                    WR_REQ: if (cmd_ack) begin
                        state_q      <= WR_WAIT;
                        cmd_wr_req_q <= 1'b0;
                    end
                    RD_REQ: if (cmd_ack) begin
                        state_q      <= RD_WAIT;
                        cmd_rd_req_q <= 1'b0;
                    end
                    WR_WAIT, RD_WAIT: if (burst_done) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign cmd_wr_req  = cmd_wr_req_q;
    assign cmd_rd_req  = cmd_rd_req_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign wfifo_flush = wfifo_flush_q;
    assign rfifo_flush = rfifo_flush_q;
    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
endmodule

// File: doc/ddr3_rw_sched.md
# ddr3_rw_sched

Burst scheduler between the camera write path and the LCD read path of the DDR3 frame buffer. It sits on the DDR3 controller clock and decides, burst by burst, whether the write FIFO is drained or the read FIFO refilled. It generates the write and read addresses, wraps them at the frame limits, and manages ping-pong frame banks. Frame-start events (`wr_load`, `rd_load`) reset the address counters and flush the FIFOs.

## Interface
- `ADDR_W`, 28, address width.
- `LEN_W`, 8, burst-length width, in 128-bit user words.
- `CNT_W`, 11, FIFO fill-count width.
- `BANK_BIT`, 25, address bit used as ping-pong bank select.
- `RD_THRESH`, 256, a read burst is needed while `rfifo_wcount` < this value.

Ports:
- `clk`  in  1  DDR3 user clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ddr3_init_done`  in  1  calibration done; no commands are issued while low.
- `wr_load`  in  1  write frame start, level (already synchronised to `clk`).
- `rd_load`  in  1  read frame start, level (already synchronised to `clk`).
- `pingpang_en`  in  1  enables the two-bank ping-pong scheme.
- `wfifo_rcount`  in  CNT_W  user words waiting in the write FIFO.
- `rfifo_wcount`  in  CNT_W  user words held in the read FIFO.
- `addr_wd_min`, `addr_wd_max`, `addr_rd_min`, `addr_rd_max`  in  ADDR_W  each  frame limits, in pixel units.
- `wd_burst_len`, `rd_burst_len`  in  LEN_W  each  burst length, in user words.
- `cmd_wr_req`  out  1  write burst request.
- `cmd_rd_req`  out  1  read burst request.
- `cmd_addr`  out  ADDR_W  burst start address.
- `cmd_len`  out  LEN_W  burst length.
- `cmd_ack`  in  1  one-cycle pulse: the controller accepted the command.
- `burst_done`  in  1  one-cycle pulse: the last word of the burst was transferred.
- `wfifo_flush`  out  1  one-cycle write-FIFO flush.
- `rfifo_flush`  out  1  one-cycle read-FIFO flush.
- `wr_bank`  out  1  bank currently being written.
- `rd_bank`  out  1  bank currently being read.

## Operation
- States: `IDLE`, `WR_REQ`, `WR_WAIT`, `RD_REQ`, `RD_WAIT`.
- Need flags:
  - `wr_need` = `wfifo_rcount >= wd_burst_len` and `wd_burst_len != 0`.
  - `rd_need` = `rfifo_wcount < RD_THRESH` and `rd_burst_len != 0`.
- `IDLE` (requires `ddr3_init_done` = 1):
  - only `wr_need` set → `WR_REQ`.
  - only `rd_need` set → `RD_REQ`.
  - both set → round-robin: the path not served last wins. After reset, write counts as served last, so read wins the first tie.
- Command issue:
  - `WR_REQ`/`RD_REQ` hold the request, `cmd_addr` and `cmd_len` stable until `cmd_ack`, then go to the matching `*_WAIT`.
  - `*_WAIT` waits for `burst_done`, then returns to `IDLE`.
- `cmd_addr` = pointer with bit `BANK_BIT` replaced by the active bank (`wr_bank` or `rd_bank`).
- Address step per burst = `len << 3`, computed at ADDR_W+1 bits so the carry is kept.
  - If pointer + step >= max, the pointer wraps to min.
  - On a write wrap with `pingpang_en` = 1, `wr_bank` toggles.
- Frame loads (rising edge detected on a registered copy of `wr_load`/`rd_load`):
  - `wr_load` rise → write pointer := `addr_wd_min`; `wfifo_flush` pulses.
  - `rd_load` rise → read pointer := `addr_rd_min`; `rfifo_flush` pulses; `rd_bank` := `~wr_bank` if `pingpang_en`, else 0.
  - A load arriving while the same path is in `*_REQ` or `*_WAIT` is held pending. It is applied in the cycle `burst_done` is seen, and that burst's pointer advance is discarded.
- `pingpang_en` = 0: both banks are forced to 0.
- `ddr3_init_done` falling in any state → `IDLE`, requests cleared. A burst already acknowledged is abandoned without a pointer advance.

## Timing
- Reset values: every output 0; pointers 0; state `IDLE`.
- Request asserts one cycle after `IDLE` samples the need flag, and deasserts in the cycle after `cmd_ack`.
- Minimum spacing between commands: `burst_done` → `IDLE` (1 cycle) → `*_REQ` (next cycle), i.e. 2 cycles from `burst_done` to the next request.
- Pointer and bank updates are registered in the `burst_done` cycle; `cmd_addr` for the next burst is therefore valid with the request.
- Flush pulses are 1 cycle wide: 2 cycles after the load rise when the path is idle, otherwise 1 cycle after `burst_done`.
- `cmd_ack` and `burst_done` are ignored outside their matching states.

## Configuration
- `DDR_SCHED_WR_PRIORITY_EN` defined: write wins every tie (fixed priority; keeps the camera from overflowing).
- Undefined: round-robin as described under Operation.

## Test plan
- Tie after reset: `wfifo_rcount` = 64, `rfifo_wcount` = 0, burst lens 64 → first `cmd_rd_req` with `cmd_addr` = `addr_rd_min`, then `cmd_wr_req` (write-first when the macro is defined).
- Pointer stepping: write min 0, max 1536, len 64 → addresses 0, 512, 1024, 0. `wr_bank` toggles on the wrap with `pingpang_en` = 1 (bit 25 of `cmd_addr` set on the fourth command).
- Pending load: `wr_load` rises during `WR_WAIT` → `wfifo_flush` pulses in the cycle after `burst_done`; the next write address is `addr_wd_min`.
- Bank capture: `rd_load` rise with `wr_bank` = 1 → `rd_bank` = 0, `rfifo_flush` pulse, next read at `addr_rd_min` with bit 25 = 0.
- Init drop: `ddr3_init_done` goes low in `RD_REQ` → `cmd_rd_req` = 0 next cycle, no pointer change; after init returns, the same address is requested again.
- Async reset mid-`WR_WAIT` → all outputs 0 immediately; no request until a need flag is seen after reset release.
